hilo_mdu: RTL and testbench
===========================

Name: hilo_mdu

Overview:
EX-stage multiply/divide unit and HI/LO register file. It executes the 9-bit hilo_op field that the decode stage places on the ID-to-EX bus: mfhi, mflo, mthi, mtlo, mult, multu, div, divu and mul.
Multiplies finish in a single cycle. Divides run an iterative 32-step restoring divider and hold the pipeline through stallreq while they run.
HI/LO commit in EX, so back-to-back hilo instructions need no forwarding.

Parameters:
DIV_STEPS, 32, number of quotient bits produced (one per BUSY cycle); fixed to the data width.

Ports:
clk  in  1  clock
rst  in  1  reset
hilo_op  in  9  {mfhi,mflo,mthi,mtlo,mult,multu,div,divu,mul}, one-hot or zero; zero means bubble or non-hilo instruction
src_a  in  32  forwarded rs value
src_b  in  32  forwarded rt value
ex_hold  in  1  EX held by an external stall; the instruction in EX does not retire this cycle
stallreq  out  1  request to hold IF..EX
busy  out  1  divider in BUSY state
rd_result  out  32  GPR write value for mfhi/mflo/mul, otherwise 0
hi_q  out  32  current HI register
lo_q  out  32  current LO register

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset HI=LO=0, state=IDLE, step counter=0. stallreq, busy and rd_result are 0 while rst is high.
- Reset during BUSY or DONE aborts the divide: next state IDLE, HI/LO=0, no partial result is written.
- States: IDLE, BUSY, DONE.
- IDLE with hilo_op[div|divu]=1:
  - latch |src_a|, |src_b| and the sign bits (div only; divu takes raw values);
  - go to BUSY, count=0;
  - stallreq=1 combinationally in this issue cycle.
- BUSY, per cycle:
  - shift the remainder/quotient pair one bit left and trial-subtract the divisor; keep the difference if it is non-negative, setting the quotient bit to 1;
  - count++; at count==31 go to DONE;
  - stallreq=1 and busy=1 throughout.
- DONE:
  - stallreq=0;
  - final sign fix (div): quotient negated if the operand signs differ; remainder takes the dividend's sign;
  - HI<=remainder and LO<=quotient at the end of the cycle unless ex_hold=1. If ex_hold=1, stay in DONE holding the result. Then go to IDLE.
  - The still-present div hilo_op must not restart a divide in DONE.
- Latency: the instruction occupies EX for 34 cycles (issue + 32 BUSY + DONE); stallreq is high for exactly 33 of them.
- Divide by zero (src_b==0), div and divu alike: same 34-cycle timing, result LO=32'hFFFFFFFF and HI=src_a, no sign fix.
- Signed corner case: div 32'h80000000 / 32'hFFFFFFFF gives LO=32'h80000000, HI=0 (wrap, no trap).
- mult/multu: 64-bit product from a combinational multiplier; {HI,LO}<=product at the clock edge, unless ex_hold. stallreq=0.
- mthi/mtlo: HI<=src_a or LO<=src_a at the edge, unless ex_hold.
- mfhi/mflo: rd_result=HI or LO as currently registered.
- mul: rd_result = low 32 bits of the signed product; HI/LO are not modified.
- hilo_op==0: no state change; rd_result=0.
- Non-div hilo ops arriving while state!=IDLE cannot occur, because the pipeline is held; the implementation ignores them.

Decomposition:
- Shared package/defines:
  - HILO_OP_WD=9;
  - bit indices HILO_MFHI=8 .. HILO_MUL=0;
  - state encodings MDU_IDLE/MDU_BUSY/MDU_DONE.
- One sub-module, mdu_div_core:
  - inputs: start, signed flag, operands;
  - outputs: quotient, remainder, done;
  - contains the counter and the shift/subtract datapath.
- hilo_mdu keeps the FSM glue, HI/LO registers, multiplier and result mux.

Test Plan:
- divu 7/2 -> stallreq high 33 cycles, instruction leaves in cycle 34; then LO=3, HI=1. A following mflo gives rd_result=3.
- div -7/2 (32'hFFFFFFF9, 2) -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- mult 32'hFFFFFFFF*2 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFE. multu with the same operands -> HI=1, LO=32'hFFFFFFFE. stallreq stays 0 for both.
- divu 5/0 -> LO=32'hFFFFFFFF, HI=5, 34-cycle timing.
- mthi 32'h1234 then mfhi back-to-back -> rd_result=32'h1234. A following mul 3*-4 -> rd_result=32'hFFFFFFF4 and HI unchanged.
- div started, then rst at BUSY cycle 10 -> next cycle stallreq=0, busy=0, HI=LO=0. A new divu 9/3 then completes with LO=3, HI=0.

Source files
------------

// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: hilo_op bit positions,
// data width and divider FSM state encoding.
package hilo_mdu_pkg;

    localparam int DATA_W     = 32;
    localparam int HILO_OP_WD = 9;

    localparam int HILO_MFHI  = 8;
    localparam int HILO_MFLO  = 7;
    localparam int HILO_MTHI  = 6;
    localparam int HILO_MTLO  = 5;
    localparam int HILO_MULT  = 4;
    localparam int HILO_MULTU = 3;
    localparam int HILO_DIV   = 2;
    localparam int HILO_DIVU  = 1;
    localparam int HILO_MUL   = 0;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring divider: operands are latched as magnitudes on start, one
// quotient bit is produced per step, and the sign fix is applied on the outputs.
module mdu_div_core
    import hilo_mdu_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(DIV_STEPS);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [DATA_W-1:0] raw_q, raw_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              dbz_q, dbz_d;

    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   diff;
    logic              a_neg;
    logic              b_neg;

    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        raw_d   = raw_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dbz_d   = dbz_q;
        a_neg   = signed_i & dividend_i[DATA_W-1];
        b_neg   = signed_i & divisor_i[DATA_W-1];
        // quo_q doubles as the dividend shift register; its MSB feeds the remainder
        rem_sh  = {rem_q, quo_q[DATA_W-1]};
        diff    = rem_sh - {1'b0, dvs_q};

        if (start_i) begin
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_neg ? -dividend_i : dividend_i;
            dvs_d   = b_neg ? -divisor_i : divisor_i;
            raw_d   = dividend_i;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            dbz_d   = (divisor_i == '0);
        end else if (step_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!diff[DATA_W]) begin
                rem_d = diff[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dvs_q   <= dvs_d;
        raw_q   <= raw_d;
        q_neg_q <= q_neg_d;
        r_neg_q <= r_neg_d;
        dbz_q   <= dbz_d;
    end

    // Divide by zero reports all-ones quotient and the untouched dividend.
    assign quotient_o  = dbz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
    assign remainder_o = dbz_q ? raw_q : (r_neg_q ? -rem_q : rem_q);
    assign done_o      = step_i && (cnt_q == CNT_W'(DIV_STEPS - 1));

endmodule

// File: rtl/hilo_mdu.sv
// EX-stage multiply/divide unit with HI/LO registers; divides stall the pipeline
// through stallreq while the iterative core runs.
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HILO_OP_WD-1:0] hilo_op,
    input  logic [DATA_W-1:0]     src_a,
    input  logic [DATA_W-1:0]     src_b,
    input  logic                  ex_hold,
    output logic                  stallreq,
    output logic                  busy,
    output logic [DATA_W-1:0]     rd_result,
    output logic [DATA_W-1:0]     hi_q,
    output logic [DATA_W-1:0]     lo_q
);

    mdu_state_e state_q, state_d;
    logic [DATA_W-1:0] hi_d, lo_d;

    logic              div_start, div_step, div_done;
    logic [DATA_W-1:0] div_quo, div_rem;
    logic              is_div;

    logic signed [2*DATA_W-1:0] a_sx, b_sx, prod_s;
    logic        [2*DATA_W-1:0] prod_u;

    assign a_sx   = (2*DATA_W)'($signed(src_a));
    assign b_sx   = (2*DATA_W)'($signed(src_b));
    assign prod_s = a_sx * b_sx;
    assign prod_u = (2*DATA_W)'(src_a) * (2*DATA_W)'(src_b);
    assign is_div = hilo_op[HILO_DIV] | hilo_op[HILO_DIVU];

    mdu_div_core #(
        .DIV_STEPS (DIV_STEPS)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .step_i      (div_step),
        .signed_i    (hilo_op[HILO_DIV]),
        .dividend_i  (src_a),
        .divisor_i   (src_b),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .done_o      (div_done)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stallreq  = 1'b0;
        busy      = 1'b0;
        rd_result = '0;
        div_start = 1'b0;
        div_step  = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (is_div) begin
                    div_start = 1'b1;
                    stallreq  = 1'b1;
                    state_d   = MDU_BUSY;
                end else begin
                    if (!ex_hold) begin
                        if (hilo_op[HILO_MULT])  {hi_d, lo_d} = prod_s;
                        if (hilo_op[HILO_MULTU]) {hi_d, lo_d} = prod_u;
                        if (hilo_op[HILO_MTHI])  hi_d = src_a;
                        if (hilo_op[HILO_MTLO])  lo_d = src_a;
                    end
                    if (hilo_op[HILO_MFHI]) rd_result = hi_q;
                    if (hilo_op[HILO_MFLO]) rd_result = lo_q;
                    if (hilo_op[HILO_MUL])  rd_result = prod_s[DATA_W-1:0];
                end
            end
            MDU_BUSY: begin
                stallreq = 1'b1;
                busy     = 1'b1;
                div_step = 1'b1;
                if (div_done) state_d = MDU_DONE;
            end
            MDU_DONE: begin
                // The div op is still on hilo_op here; it must not restart.
                if (!ex_hold) begin
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                    state_d = MDU_IDLE;
                end
            end
            default: state_d = MDU_IDLE;
        endcase

        if (rst) begin
            stallreq  = 1'b0;
            busy      = 1'b0;
            rd_result = '0;
            div_start = 1'b0;
            div_step  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: the driver pushes expected results from an
// arithmetic reference model, the monitor checks each instruction as it retires.
module tb_hilo_mdu;
    import hilo_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  hilo_op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        ex_hold = 1'b0;
    logic        stallreq, busy;
    logic [31:0] rd_result, hi_q, lo_q;

    hilo_mdu #(.DIV_STEPS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .hilo_op   (hilo_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .ex_hold   (ex_hold),
        .stallreq  (stallreq),
        .busy      (busy),
        .rd_result (rd_result),
        .hi_q      (hi_q),
        .lo_q      (lo_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          stalls;
        logic [31:0] rd;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic        hold_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain MIPS arithmetic on the architectural HI/LO.
    task automatic issue(input int opi, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic signed [63:0] ps;
        logic [63:0] pu;
        int          sa, sb, guard;
        logic        retired;
        string       nm[9] = '{"mul", "divu", "div", "multu", "mult", "mtlo", "mthi", "mflo", "mfhi"};
        sa = a;
        sb = b;
        ps = $signed(a) * $signed(b);
        pu = {32'b0, a} * {32'b0, b};
        e.name   = nm[opi];
        e.stalls = 0;
        e.rd     = '0;
        case (opi)
            HILO_MFHI:  e.rd = model_hi;
            HILO_MFLO:  e.rd = model_lo;
            HILO_MTHI:  model_hi = a;
            HILO_MTLO:  model_lo = a;
            HILO_MULT:  {model_hi, model_lo} = ps;
            HILO_MULTU: {model_hi, model_lo} = pu;
            HILO_MUL:   e.rd = ps[31:0];
            HILO_DIV, HILO_DIVU: begin
                e.stalls = 33;
                if (b == 0) begin
                    model_lo = 32'hFFFFFFFF;
                    model_hi = a;
                end else if (opi == HILO_DIVU) begin
                    model_lo = a / b;
                    model_hi = a % b;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    model_lo = 32'h80000000;
                    model_hi = 32'h0;
                end else begin
                    model_lo = sa / sb;
                    model_hi = sa % sb;
                end
            end
            default: ;
        endcase
        e.hi = model_hi;
        e.lo = model_lo;
        sb_q.push_back(e);

        hilo_op = 9'b1 << opi;
        src_a   = a;
        src_b   = b;
        guard   = 0;
        forever begin
            ex_hold = hold_en && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            retired = !stallreq && !ex_hold;
            @(posedge clk);
            #1;
            if (retired) break;
            guard++;
            if (guard > 300) begin
                chk("retire_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        hilo_op = '0;
        ex_hold = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: counts stall cycles and checks each instruction at retire.
    int   stall_cnt = 0;
    logic pend = 1'b0;
    exp_t pend_e;
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            chk({pend_e.name, "_hi"}, hi_q, pend_e.hi);
            chk({pend_e.name, "_lo"}, lo_q, pend_e.lo);
            pend = 1'b0;
        end
        if (rst) begin
            stall_cnt = 0;
        end else if (hilo_op != '0) begin
            if (stallreq) begin
                chk({"busy_", (stall_cnt == 0) ? "issue" : "run"}, 32'(busy), 32'(stall_cnt != 0));
                stall_cnt++;
            end else if (!ex_hold) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_retire", 32'(hilo_op), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_rd"}, rd_result, e.rd);
                    chk({e.name, "_stall_cycles"}, 32'(stall_cnt), 32'(e.stalls));
                    pend   = 1'b1;
                    pend_e = e;
                end
                stall_cnt = 0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd", rd_result, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi_q, 32'd0);
        chk("rst_lo", lo_q, 32'd0);
        @(posedge clk);
        #1;

        issue(HILO_DIVU, 32'd7, 32'd2);
        issue(HILO_MFLO, 32'd0, 32'd0);
        issue(HILO_DIV, 32'hFFFFFFF9, 32'd2);
        issue(HILO_MULT, 32'hFFFFFFFF, 32'd2);
        issue(HILO_MULTU, 32'hFFFFFFFF, 32'd2);
        issue(HILO_DIVU, 32'd5, 32'd0);
        issue(HILO_MTHI, 32'h1234, 32'd0);
        issue(HILO_MFHI, 32'd0, 32'd0);
        issue(HILO_MUL, 32'd3, 32'hFFFFFFFC);
        issue(HILO_MFHI, 32'd0, 32'd0);

        // Abort a divide partway through with reset.
        hilo_op = 9'b1 << HILO_DIV;
        src_a   = 32'd1000;
        src_b   = 32'd7;
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_stallreq", 32'(stallreq), 32'd0);
        chk("abort_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        hilo_op = '0;
        @(negedge clk);
        chk("abort_stallreq", 32'(stallreq), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi_q, 32'd0);
        chk("abort_lo", lo_q, 32'd0);
        model_hi = '0;
        model_lo = '0;
        @(posedge clk);
        #1;

        issue(HILO_DIVU, 32'd9, 32'd3);
        issue(HILO_DIV, 32'h80000000, 32'hFFFFFFFF);
        issue(HILO_DIV, 32'hFFFFFFF0, 32'd0);
        issue(HILO_DIV, 32'd7, 32'hFFFFFFFE);

        hold_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue($urandom_range(0, 8), pick(), pick());
        end
        hold_en = 1'b0;

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
